obi_data_mem_responder: RTL and testbench

//  OBI 1.x subordinate that answers the core's data-side initiator (the source of data_obi_busy_mem_i).
//  - Contains a word-addressed RAM.
//  - Adds a configurable grant wait and response latency, plus an optional gnt_stall_i hook.
//  - Gives the data port real back-pressure in simulation and FPGA builds.

---
 rtl/obi_data_mem_responder_pkg.sv | 38 +++
 rtl/obi_data_mem_responder_checker.sv | 31 +++
 rtl/obi_data_mem_responder_resp_delay.sv | 34 +++
 rtl/obi_data_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_obi_data_mem_responder.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_data_mem_responder_pkg.sv
// Shared types and helpers for the OBI data-memory responder.
//  - obi_resp_t  : one response beat {valid, rdata, err} carried by the latency pipeline
//  - gnt_state_e : grant FSM states
//  - be_merge    : byte-enable merge of write data into an existing RAM word
package obi_data_mem_responder_pkg;

  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;
  localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;

  typedef struct packed {
    logic                  valid;
    logic [OBI_DATA_W-1:0] rdata;
    logic                  err;
  } obi_resp_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } gnt_state_e;

  // Replace only the enabled byte lanes of old_word with wdata.
  function automatic logic [OBI_DATA_W-1:0] be_merge(
    input logic [OBI_DATA_W-1:0] old_word,
    input logic [OBI_DATA_W-1:0] wdata,
    input logic [OBI_BE_W-1:0]   be
  );
    logic [OBI_DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < int'(OBI_BE_W); b++) begin
      if (be[b]) begin
        merged[8*b +: 8] = wdata[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/obi_data_mem_responder_checker.sv
// Protocol and bookkeeping assertions for obi_data_mem_responder (simulation only).
//  Observes the request channel, the grant, rvalid and the outstanding counter.
module obi_data_mem_responder_checker #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned OUT_W           = 2
) (
  input logic             clk,
  input logic             rst_n,
  input logic             req_i,
  input logic             gnt_i,
  input logic [31:0]      addr_i,
  input logic             we_i,
  input logic [3:0]       be_i,
  input logic [31:0]      wdata_i,
  input logic             rvalid_i,
  input logic [OUT_W-1:0] outst_i
);

  // An initiator waiting for grant must keep the request and its payload steady.
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (req_i && !gnt_i) |=> (req_i && $stable(addr_i) && $stable(we_i) &&
                           $stable(be_i) && $stable(wdata_i)));

  a_outst_max: assert property (@(posedge clk) disable iff (!rst_n)
    outst_i <= OUT_W'(MAX_OUTSTANDING));

  // A response can only leave if something was granted and not yet answered.
  a_outst_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    rvalid_i |-> (outst_i != '0));

endmodule

// File: rtl/obi_data_mem_responder_resp_delay.sv
// obi_resp_delay: fixed-latency shift pipeline for OBI responses.
//  clk, rst_n : clock, asynchronous active-low reset (clears every stage, dropping in-flight beats)
//  resp_i     : beat entering on the accept edge
//  resp_o     : beat leaving LAT cycles later
module obi_resp_delay
  import obi_data_mem_responder_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  obi_resp_t resp_i,
  output obi_resp_t resp_o
);

  obi_resp_t stage_q [LAT];

  // Shift register of response beats; the last stage drives the port directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LAT); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= resp_i;
      for (int i = 1; i < int'(LAT); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign resp_o = stage_q[LAT-1];

endmodule

// File: rtl/obi_data_mem_responder.sv
// OBI 1.x subordinate serving the core's data port from a word-addressed RAM.
//  Ports: clk/rst_n (async active-low); req_i/gnt_o handshake; addr_i (byte address),
//  we_i, be_i, wdata_i request payload; rvalid_o/rdata_o/err_o in-order response;
//  gnt_stall_i test hook that holds gnt_o low.
//  Grant waits GNT_WAIT held-request cycles and respects MAX_OUTSTANDING; responses
//  appear RVALID_LAT cycles after the accept edge. Misaligned or out-of-range
//  accesses leave the RAM untouched and answer err=1, rdata=0.
module obi_data_mem_responder
  import obi_data_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned GNT_WAIT        = 0,
  parameter int unsigned RVALID_LAT      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter string       INIT_FILE       = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [OBI_ADDR_W-1:0] addr_i,
  input  logic                  we_i,
  input  logic [OBI_BE_W-1:0]   be_i,
  input  logic [OBI_DATA_W-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [OBI_DATA_W-1:0] rdata_o,
  output logic                  err_o,
  input  logic                  gnt_stall_i
);

  localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned WCNT_W = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  gnt_state_e            state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [OUT_W-1:0]      outst_q, outst_d;
  logic                  block_s;
  logic                  accept_s;
  logic                  addr_err_s;
  logic [IDX_W-1:0]      idx_s;
  logic [OBI_DATA_W-1:0] mem_q [MEM_WORDS];
  obi_resp_t             resp_in_s, resp_out_s;

  // A response leaving this cycle frees its slot, so a full counter does not block then.
  assign block_s    = gnt_stall_i ||
                      ((outst_q == OUT_W'(MAX_OUTSTANDING)) && !rvalid_o);
  assign accept_s   = req_i && gnt_o;
  assign addr_err_s = (addr_i[1:0] != 2'b00) ||
                      ({2'b00, addr_i[OBI_ADDR_W-1:2]} >= 32'(MEM_WORDS));
  assign idx_s      = addr_i[IDX_W+1:2];

  // Grant FSM next state, wait counter and combinational grant.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    gnt_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i && (GNT_WAIT == 0)) begin
          gnt_o = !block_s;
        end else if (req_i) begin
          state_d = S_WAIT;
          wcnt_d  = WCNT_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!req_i) begin
          // Request withdrawn before grant: restart the wait from scratch.
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else if ((wcnt_q >= WCNT_W'(GNT_WAIT)) && !block_s) begin
          gnt_o   = 1'b1;
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q < WCNT_W'(GNT_WAIT)) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // Grant FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Outstanding count: accept and response in the same cycle cancel out.
  always_comb begin
    outst_d = outst_q;
    if (accept_s && !rvalid_o) begin
      outst_d = outst_q + OUT_W'(1);
    end else if (!accept_s && rvalid_o) begin
      outst_d = outst_q - OUT_W'(1);
    end else begin
      outst_d = outst_q;
    end
  end

  // Outstanding counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q <= '0;
    end else begin
      outst_q <= outst_d;
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept_s && we_i && !addr_err_s) begin
      mem_q[idx_s] <= be_merge(mem_q[idx_s], wdata_i, be_i);
    end
  end

  // Response beat formed on the accept cycle; the read sees the RAM before this cycle's write.
  always_comb begin
    resp_in_s       = '0;
    resp_in_s.valid = accept_s;
    resp_in_s.err   = accept_s && addr_err_s;
    if (accept_s && !we_i && !addr_err_s) begin
      resp_in_s.rdata = mem_q[idx_s];
    end else begin
      resp_in_s.rdata = 32'h0000_0000;
    end
  end

  obi_resp_delay #(
    .LAT (RVALID_LAT)
  ) u_resp_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .resp_i (resp_in_s),
    .resp_o (resp_out_s)
  );

  assign rvalid_o = resp_out_s.valid;
  assign rdata_o  = resp_out_s.rdata;
  assign err_o    = resp_out_s.err;

  obi_data_mem_responder_checker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .OUT_W           (OUT_W)
  ) u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .gnt_i    (gnt_o),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .wdata_i  (wdata_i),
    .rvalid_i (rvalid_o),
    .outst_i  (outst_q)
  );

endmodule

// File: tb/tb_obi_data_mem_responder.sv
// Self-checking bench for obi_data_mem_responder. Three instances cover different
// grant-wait / latency configurations; a transaction-level reference model predicts
// grant, response timing and read data from the protocol rules.
module tb_obi_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req    [3];
  logic        gnt    [3];
  logic        we     [3];
  logic        stall  [3];
  logic        rvalid [3];
  logic        err    [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [31:0] rdata  [3];
  logic [3:0]  be     [3];

  int          gw_p    [3] = '{0, 2, 0};
  int          lat_p   [3] = '{1, 2, 4};
  int          max_p   [3] = '{2, 2, 2};
  int unsigned words_p [3] = '{1024, 1024, 64};

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int gap; } stim_t;
  typedef struct { int due; logic [31:0] rdata; logic err; } exp_t;
  typedef struct { int cyc; logic [31:0] rdata; logic err; } rsp_t;

  stim_t       stim_q [$];
  exp_t        expq [$];
  rsp_t        rsp_log [$];
  bit          gnt_log [$];
  logic [31:0] mmem [3][16];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  obi_data_mem_responder #(.MEM_WORDS(1024), .GNT_WAIT(0), .RVALID_LAT(1), .MAX_OUTSTANDING(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
    .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .gnt_stall_i(stall[0]));
  obi_data_mem_responder #(.MEM_WORDS(1024), .GNT_WAIT(2), .RVALID_LAT(2), .MAX_OUTSTANDING(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
    .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .gnt_stall_i(stall[1]));
  obi_data_mem_responder #(.MEM_WORDS(64), .GNT_WAIT(0), .RVALID_LAT(4), .MAX_OUTSTANDING(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
    .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]),
    .gnt_stall_i(stall[2]));

  task automatic push_stim(input logic w, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d, input int gap);
    stim_t s;
    s.we = w; s.addr = a; s.be = b; s.wdata = d; s.gap = gap;
    stim_q.push_back(s);
  endtask

  // Plays stim_q into one instance, predicting every cycle from the protocol rules.
  task automatic run_traffic(input int inst, input string tag, input int max_cycles,
                             input bit rnd_stall, input bit must_drain);
    stim_t       cur;
    exp_t        e;
    bit          active, req_now, stall_now, exp_rv, exp_g, a_err;
    int          gap_left, held;
    logic [31:0] word;
    cur.we = 1'b0; cur.addr = 32'h0; cur.be = 4'h0; cur.wdata = 32'h0; cur.gap = 0;
    active = 1'b0; gap_left = 0; held = 0;
    gnt_log.delete();
    rsp_log.delete();
    for (int c = 0; c < max_cycles; c++) begin
      if (!active && stim_q.size() > 0) begin
        cur = stim_q.pop_front();
        active = 1'b1;
        gap_left = cur.gap;
      end
      if (!active && expq.size() == 0) break;
      req_now   = active && (gap_left == 0);
      stall_now = rnd_stall && ($urandom_range(0, 3) == 0);
      req[inst] = req_now; we[inst] = cur.we; addr[inst] = cur.addr;
      be[inst] = cur.be; wdata[inst] = cur.wdata; stall[inst] = stall_now;
      @(negedge clk);
      exp_rv = (expq.size() > 0) && (expq[0].due == c);
      exp_g  = req_now && (held >= gw_p[inst]) && !stall_now &&
               ((expq.size() < max_p[inst]) || exp_rv);
      checks++;
      if (gnt[inst] !== exp_g) begin
        failures++;
        $display("FAIL %s gnt inst=%0d cyc=%0d: got %b expected %b", tag, inst, c, gnt[inst], exp_g);
      end
      checks++;
      if (rvalid[inst] !== exp_rv) begin
        failures++;
        $display("FAIL %s rvalid inst=%0d cyc=%0d: got %b expected %b", tag, inst, c, rvalid[inst], exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if (rdata[inst] !== expq[0].rdata || err[inst] !== expq[0].err) begin
          failures++;
          $display("FAIL %s resp inst=%0d cyc=%0d: got rdata=%h err=%b expected rdata=%h err=%b",
                   tag, inst, c, rdata[inst], err[inst], expq[0].rdata, expq[0].err);
        end
        void'(expq.pop_front());
      end
      if (rvalid[inst] === 1'b1) rsp_log.push_back('{c, rdata[inst], err[inst]});
      gnt_log.push_back(gnt[inst] === 1'b1);
      if (exp_g) begin
        word  = cur.addr >> 2;
        a_err = (cur.addr[1:0] != 2'b00) || (word >= 32'(words_p[inst]));
        e.due = c + lat_p[inst];
        e.err = a_err;
        e.rdata = (!cur.we && !a_err) ? mmem[inst][word[3:0]] : 32'h0;
        expq.push_back(e);
        if (cur.we && !a_err) begin
          for (int b = 0; b < 4; b++) begin
            if (cur.be[b]) mmem[inst][word[3:0]][8*b +: 8] = cur.wdata[8*b +: 8];
          end
        end
        active = 1'b0;
      end
      if (req_now && !exp_g) held++;
      else held = 0;
      if (active && gap_left > 0) gap_left--;
      @(posedge clk); #1;
    end
    req[inst] = 1'b0;
    stall[inst] = 1'b0;
    if (must_drain) begin
      checks++;
      if (active || stim_q.size() != 0 || expq.size() != 0) begin
        failures++;
        $display("FAIL %s drain inst=%0d: pending stim=%0d resp=%0d expected none",
                 tag, inst, stim_q.size(), expq.size());
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; stall[i] = 1'b0;
      addr[i] = 32'h0; wdata[i] = 32'h0; be[i] = 4'h0;
    end
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gnt[i] !== 1'b0 || rvalid[i] !== 1'b0 || rdata[i] !== 32'h0 || err[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d: got gnt=%b rvalid=%b rdata=%h err=%b expected all 0",
                 i, gnt[i], rvalid[i], rdata[i], err[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_rw();
    push_stim(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0);
    push_stim(1'b0, 32'h10, 4'hF, 32'h0, 0);
    run_traffic(0, "basic_rw", 50, 1'b0, 1'b1);
    checks++;
    if (gnt_log.size() < 2 || gnt_log[0] !== 1'b1 || gnt_log[1] !== 1'b1) begin
      failures++;
      $display("FAIL basic_rw same_cycle_grant: got %p expected first two grants 1", gnt_log);
    end
    checks++;
    if (rsp_log.size() != 2) begin
      failures++;
      $display("FAIL basic_rw resp_count: got %0d expected 2", rsp_log.size());
    end else if (rsp_log[0].cyc != 1 || rsp_log[1].cyc != 2 ||
                 rsp_log[1].rdata !== 32'hDEAD_BEEF || rsp_log[1].err !== 1'b0) begin
      failures++;
      $display("FAIL basic_rw read_back: got cyc=%0d/%0d rdata=%h err=%b expected 1/2 DEADBEEF 0",
               rsp_log[0].cyc, rsp_log[1].cyc, rsp_log[1].rdata, rsp_log[1].err);
    end
  endtask

  task automatic test_byte_enable();
    push_stim(1'b1, 32'h20, 4'hF, 32'h1122_3344, 1);
    push_stim(1'b1, 32'h20, 4'h1, 32'h0000_00AA, 0);
    push_stim(1'b0, 32'h20, 4'hF, 32'h0, 2);
    run_traffic(0, "byte_enable", 50, 1'b0, 1'b1);
    checks++;
    if (rsp_log.size() != 3 || rsp_log[2].rdata !== 32'h1122_33AA) begin
      failures++;
      $display("FAIL byte_enable merge: got %0d resps last=%h expected 3 resps last=112233aa",
               rsp_log.size(), (rsp_log.size() > 0) ? rsp_log[rsp_log.size()-1].rdata : 32'h0);
    end
  endtask

  task automatic test_grant_wait();
    push_stim(1'b1, 32'h8, 4'hF, 32'h0BAD_CAFE, 0);
    run_traffic(1, "grant_wait", 50, 1'b0, 1'b1);
    checks++;
    if (gnt_log.size() < 3 || gnt_log[0] !== 1'b0 || gnt_log[1] !== 1'b0 || gnt_log[2] !== 1'b1) begin
      failures++;
      $display("FAIL grant_wait third_cycle: got %p expected 0,0,1", gnt_log);
    end
    checks++;
    if (rsp_log.size() != 1 || rsp_log[0].cyc != 4) begin
      failures++;
      $display("FAIL grant_wait rvalid_cycle: got %0d resps first_cyc=%0d expected 1 at 4",
               rsp_log.size(), (rsp_log.size() > 0) ? rsp_log[0].cyc : -1);
    end
  endtask

  task automatic test_backpressure();
    bit pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) push_stim(1'b1, 32'(i * 4), 4'hF, $urandom, 0);
    run_traffic(2, "backpressure", 100, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (gnt_log.size() <= i || gnt_log[i] !== pat[i]) begin
        failures++;
        $display("FAIL backpressure gnt_pattern cyc=%0d: got %b expected %b", i,
                 (gnt_log.size() > i) ? gnt_log[i] : 1'b0, pat[i]);
      end
    end
    checks++;
    if (rsp_log.size() != 8) begin
      failures++;
      $display("FAIL backpressure resp_count: got %0d expected 8", rsp_log.size());
    end
  endtask

  task automatic test_addr_error();
    push_stim(1'b1, 32'h0, 4'hF, 32'hA5A5_A5A5, 0);
    push_stim(1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 0);
    push_stim(1'b1, 32'h3, 4'hF, 32'hFFFF_FFFF, 0);
    push_stim(1'b0, 32'h3, 4'hF, 32'h0, 0);
    push_stim(1'b0, 32'h1000, 4'hF, 32'h0, 0);
    push_stim(1'b0, 32'h0, 4'hF, 32'h0, 0);
    run_traffic(0, "addr_error", 60, 1'b0, 1'b1);
    checks++;
    if (rsp_log.size() != 6) begin
      failures++;
      $display("FAIL addr_error resp_count: got %0d expected 6", rsp_log.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (rsp_log[i].err !== 1'b1 || rsp_log[i].rdata !== 32'h0) begin
          failures++;
          $display("FAIL addr_error resp%0d: got err=%b rdata=%h expected err=1 rdata=0",
                   i, rsp_log[i].err, rsp_log[i].rdata);
        end
      end
      checks++;
      if (rsp_log[5].rdata !== 32'hA5A5_A5A5 || rsp_log[5].err !== 1'b0) begin
        failures++;
        $display("FAIL addr_error ram_unchanged: got %h err=%b expected a5a5a5a5 err=0",
                 rsp_log[5].rdata, rsp_log[5].err);
      end
    end
  endtask

  task automatic test_reset_inflight();
    push_stim(1'b0, 32'h0, 4'hF, 32'h0, 0);
    run_traffic(2, "reset_inflight_pre", 1, 1'b0, 1'b0);
    rst_n = 1'b0;
    expq.delete();
    @(negedge clk);
    checks++;
    if (gnt[2] !== 1'b0 || rvalid[2] !== 1'b0 || rdata[2] !== 32'h0 || err[2] !== 1'b0) begin
      failures++;
      $display("FAIL reset_inflight outputs: got gnt=%b rvalid=%b rdata=%h err=%b expected all 0",
               gnt[2], rvalid[2], rdata[2], err[2]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_stim(1'b1, 32'h3C, 4'hF, 32'h5A5A_1234, 0);
    push_stim(1'b0, 32'h3C, 4'hF, 32'h0, 0);
    run_traffic(2, "reset_inflight_post", 60, 1'b0, 1'b1);
    checks++;
    if (gnt_log.size() < 1 || gnt_log[0] !== 1'b1 || rsp_log.size() != 2 ||
        rsp_log[1].rdata !== 32'h5A5A_1234) begin
      failures++;
      $display("FAIL reset_inflight after_reset: got first_gnt=%b resps=%0d expected 1 and 2 with 5a5a1234",
               (gnt_log.size() > 0) ? gnt_log[0] : 1'b0, rsp_log.size());
    end
  endtask

  task automatic test_random(input int inst);
    int          kind;
    logic [31:0] a;
    for (int w = 0; w < 16; w++) push_stim(1'b1, 32'(w * 4), 4'hF, $urandom, 0);
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (kind == 1) a = 32'((words_p[inst] + $urandom_range(0, 3)) * 4);
      else a = 32'($urandom_range(0, 15) * 4);
      push_stim($urandom_range(0, 1) == 1, a, 4'($urandom_range(0, 15)), $urandom,
                int'($urandom_range(0, 2)));
    end
    run_traffic(inst, "random", 2000, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_byte_enable();
    test_grant_wait();
    test_backpressure();
    test_addr_error();
    test_reset_inflight();
    test_random(0);
    test_random(1);
    test_random(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
